// File: rtl/twos_comp_pkg.sv
// Shared encodings and configuration checks for the chunk-serial two's-complement unit.
package twos_comp_pkg;

    localparam logic [1:0] MODE_PASS   = 2'b00;
    localparam logic [1:0] MODE_NEG    = 2'b01;
    localparam logic [1:0] MODE_ABS    = 2'b10;
    localparam logic [1:0] MODE_NEGABS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic bit width_ok(int width, int chunk);
        return (chunk >= 1) && (width >= chunk) && ((width % chunk) == 0);
    endfunction

    // Whether the operand is bit-inverted (and +1 injected) for a given mode and sign.
    function automatic logic inv_for(logic [1:0] mode, logic sign);
        logic inv;
        case (mode)
            MODE_PASS:   inv = 1'b0;
            MODE_NEG:    inv = 1'b1;
            MODE_ABS:    inv = sign;
            default:     inv = ~sign;
        endcase
        return inv;
    endfunction

endpackage

// File: rtl/twos_comp_chunk.sv
// Combinational CHUNK-bit slice: sum = (a ^ {CHUNK{inv}}) + cin, with carry out.
module twos_comp_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic             inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/twos_complement_seq.sv
// Chunk-serial pass/negate/abs/negabs; result valid NCHUNK edges after accept.
// Result held in DONE until out_ready; no new operand accepted until back in IDLE.
module twos_complement_seq
    import twos_comp_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("twos_complement_seq: WIDTH must be a non-zero multiple of CHUNK");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              inv_q, inv_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    logic [31:0]       base;
    logic [CHUNK-1:0]  a_chunk;
    logic [CHUNK-1:0]  sum_chunk;
    logic              cout;

    assign base    = 32'(idx_q) * CHUNK;
    assign a_chunk = op_q[base +: CHUNK];

    // Single slice, time-multiplexed over the chunks by idx_q.
    twos_comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_chunk),
        .inv  (inv_q),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        inv_d   = inv_q;
        op_d    = op_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d    = in_data;
                    inv_d   = inv_for(mode, in_data[WIDTH-1]);
                    carry_d = inv_d;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[base +: CHUNK] = sum_chunk;
                if (idx_q == LAST_IDX) begin
                    // Final carry-out is dropped; flags are evaluated on the completed result.
                    carry_d = 1'b0;
                    idx_d   = '0;
                    ovf_d   = inv_q && (op_q == MIN_VAL);
                    zero_d  = (res_d == '0);
                    state_d = ST_DONE;
                end else begin
                    carry_d = cout;
                    idx_d   = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            inv_q   <= 1'b0;
            op_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            inv_q   <= inv_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_twos_complement_seq.sv
// Bench for twos_complement_seq in three configurations: 64/16, 32/8 and 32/32.
module tb_twos_complement_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv0, iv1, iv2, rd0, rd1, rd2;
    logic        ir0, ir1, ir2, ov0, ov1, ov2;
    logic        of0, of1, of2, z0, z1, z2;
    logic [1:0]  m0, m1, m2;
    logic [63:0] id0, od0;
    logic [31:0] id1, od1, id2, od2;

    twos_complement_seq #(.WIDTH(64), .CHUNK(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .mode(m0),
        .out_valid(ov0), .out_ready(rd0), .out_data(od0), .out_ovf(of0), .out_zero(z0));
    twos_complement_seq #(.WIDTH(32), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .mode(m1),
        .out_valid(ov1), .out_ready(rd1), .out_data(od1), .out_ovf(of1), .out_zero(z1));
    twos_complement_seq #(.WIDTH(32), .CHUNK(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .mode(m2),
        .out_valid(ov2), .out_ready(rd2), .out_data(od2), .out_ovf(of2), .out_zero(z2));

    typedef struct packed {
        logic        ir;
        logic        ov;
        logic        ovf;
        logic        zero;
        logic [63:0] d;
    } obs_t;

    typedef struct packed {
        logic [63:0] d;
        logic        ovf;
        logic        zero;
    } exp_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic int width_of(int k);
        return (k == 0) ? 64 : 32;
    endfunction

    function automatic int nchunk_of(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    // Reference: plain arithmetic on a w-bit signed value.
    function automatic exp_t model(int k, logic [63:0] x_in, logic [1:0] m);
        exp_t        e;
        int          w    = width_of(k);
        logic [63:0] mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        logic [63:0] minv = 64'd1 << (w - 1);
        logic [63:0] x    = x_in & mask;
        logic [63:0] neg  = (64'd0 - x) & mask;
        logic        neg_sign = ((x & minv) != 64'd0);
        case (m)
            2'd0:    e.d = x;
            2'd1:    e.d = neg;
            2'd2:    e.d = neg_sign ? neg : x;
            default: e.d = neg_sign ? x : neg;
        endcase
        e.ovf  = (x == minv) && (m == 2'd1 || m == 2'd2);
        e.zero = (e.d == 64'd0);
        return e;
    endfunction

    task automatic set_in(int k, logic v, logic [63:0] d, logic [1:0] m);
        case (k)
            0:       begin iv0 = v; id0 = d;        m0 = m; end
            1:       begin iv1 = v; id1 = d[31:0];  m1 = m; end
            default: begin iv2 = v; id2 = d[31:0];  m2 = m; end
        endcase
    endtask

    task automatic set_rdy(int k, logic r);
        case (k)
            0:       rd0 = r;
            1:       rd1 = r;
            default: rd2 = r;
        endcase
    endtask

    function automatic obs_t sample(int k);
        obs_t o;
        case (k)
            0:       begin o.ir = ir0; o.ov = ov0; o.ovf = of0; o.zero = z0; o.d = od0; end
            1:       begin o.ir = ir1; o.ov = ov1; o.ovf = of1; o.zero = z1; o.d = {32'd0, od1}; end
            default: begin o.ir = ir2; o.ov = ov2; o.ovf = of2; o.zero = z2; o.d = {32'd0, od2}; end
        endcase
        return o;
    endfunction

    // Called #1 after the accept edge; counts edges until out_valid.
    task automatic wait_result(int k, string tag, exp_t e);
        int   lat = 0;
        obs_t o;
        do begin
            @(posedge clk); #1;
            lat++;
            o = sample(k);
        end while (!o.ov && lat < 20);
        chk({tag, "_lat"},  64'(lat), 64'(nchunk_of(k)));
        chk({tag, "_data"}, o.d, e.d);
        chk({tag, "_ovf"},  64'(o.ovf), 64'(e.ovf));
        chk({tag, "_zero"}, 64'(o.zero), 64'(e.zero));
    endtask

    task automatic run_op(int k, logic [63:0] x, logic [1:0] m, int hold, string tag);
        exp_t e = model(k, x, m);
        obs_t o;
        @(negedge clk);
        o = sample(k);
        chk({tag, "_inrdy"}, 64'(o.ir), 64'd1);
        set_in(k, 1'b1, x, m);
        @(posedge clk); #1;
        set_in(k, 1'b0, {$urandom, $urandom}, 2'($urandom));
        wait_result(k, tag, e);
        repeat (hold) begin
            @(negedge clk);
            set_in(k, 1'b1, {$urandom, $urandom}, 2'($urandom));
            @(posedge clk); #1;
            o = sample(k);
            chk({tag, "_hold_d"},  o.d, e.d);
            chk({tag, "_hold_ir"}, 64'(o.ir), 64'd0);
        end
        @(negedge clk);
        set_in(k, 1'b0, 64'd0, 2'd0);
        set_rdy(k, 1'b1);
        @(posedge clk); #1;
        o = sample(k);
        chk({tag, "_ack_ov"}, 64'(o.ov), 64'd0);
        chk({tag, "_ack_ir"}, 64'(o.ir), 64'd1);
        set_rdy(k, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        obs_t        o;
        exp_t        ea, eb;
        int          n;
        logic [63:0] x;
        logic [1:0]  m;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(k, 1'b0, 64'd0, 2'd0);
            set_rdy(k, 1'b0);
        end
        #1;
        o = sample(0);
        chk("rst_ir",   64'(o.ir),   64'd1);
        chk("rst_ov",   64'(o.ov),   64'd0);
        chk("rst_data", o.d,         64'd0);
        chk("rst_ovf",  64'(o.ovf),  64'd0);
        chk("rst_zero", 64'(o.zero), 64'd0);
        #21 rst_n = 1'b1;

        run_op(0, 64'h0000_0000_0000_0001, 2'd1, 0, "neg1");
        run_op(0, 64'h8000_0000_0000_0000, 2'd2, 1, "absmin");
        run_op(0, 64'h8000_0000_0000_0000, 2'd3, 0, "negabsmin");
        run_op(0, 64'h0, 2'd1, 0, "neg0");
        run_op(0, 64'hFFFF_FFFF_FFFF_FF85, 2'd2, 0, "absneg");
        run_op(0, 64'h1234, 2'd0, 0, "pass");

        // Backpressure with in_valid held high through DONE.
        ea = model(0, 64'h0000_0000_00AB_CDEF, 2'd1);
        eb = model(0, 64'hFFFF_0000_0000_0001, 2'd2);
        @(negedge clk);
        set_in(0, 1'b1, 64'h0000_0000_00AB_CDEF, 2'd1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'd0, 2'd0);
        wait_result(0, "bp_a", ea);
        @(negedge clk);
        set_in(0, 1'b1, 64'hFFFF_0000_0000_0001, 2'd2);
        repeat (5) begin
            @(posedge clk); #1;
            o = sample(0);
            chk("bp_hold_d",  o.d, ea.d);
            chk("bp_hold_ir", 64'(o.ir), 64'd0);
            chk("bp_hold_ov", 64'(o.ov), 64'd1);
        end
        @(negedge clk);
        set_rdy(0, 1'b1);
        @(posedge clk); #1;
        o = sample(0);
        chk("bp_ack_ov", 64'(o.ov), 64'd0);
        chk("bp_ack_ir", 64'(o.ir), 64'd1);
        set_rdy(0, 1'b0);
        @(posedge clk); #1;
        o = sample(0);
        chk("bp_accept_ir", 64'(o.ir), 64'd0);
        set_in(0, 1'b0, 64'd0, 2'd0);
        wait_result(0, "bp_b", eb);
        @(negedge clk);
        set_rdy(0, 1'b1);
        @(posedge clk); #1;
        set_rdy(0, 1'b0);

        // Asynchronous reset after two chunks of a negate.
        @(negedge clk);
        set_in(0, 1'b1, 64'h77, 2'd1);
        @(posedge clk); #1;
        set_in(0, 1'b0, 64'd0, 2'd0);
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        o = sample(0);
        chk("arst_ov",   64'(o.ov), 64'd0);
        chk("arst_ir",   64'(o.ir), 64'd1);
        chk("arst_data", o.d, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ov0) n++;
        end
        chk("arst_stale", 64'(n), 64'd0);
        run_op(0, 64'h5, 2'd1, 1, "neg5");

        run_op(1, 64'h0000_0100, 2'd1, 0, "w32c8");
        run_op(2, 64'h7FFF_FFFF, 2'd1, 0, "w32c32");
        run_op(2, 64'h0, 2'd1, 0, "w32c32_neg0");
        run_op(1, 64'h8000_0000, 2'd2, 0, "w32c8_absmin");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                case ($urandom_range(0, 7))
                    0:       x = 64'd0;
                    1:       x = (k == 0) ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
                    2:       x = {64{1'b1}};
                    3:       x = 64'(CHUNK_EDGE(k));
                    default: x = {$urandom, $urandom};
                endcase
                m = 2'($urandom_range(0, 3));
                run_op(k, x, m, $urandom_range(0, 2), $sformatf("rnd%0d_%0d", k, i));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Values that make the inversion carry ripple exactly to a chunk boundary.
    function automatic logic [63:0] CHUNK_EDGE(int k);
        logic [63:0] v;
        v = (k == 0) ? 64'h0000_0000_0001_0000 : 64'h0000_0100;
        return v;
    endfunction

endmodule
